// File: rtl/ingress_page_writer.sv
// Ingress page writer: turns a port's drained header+payload word stream into 8-word linked
// SRAM pages and emits one descriptor per packet to the enqueue logic.
module ingress_page_writer #(
  parameter int unsigned PAGE_AW = 11,
  parameter int unsigned PAGE_W  = 3,
  parameter int unsigned LEN_W   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [15:0]                in_data,
  input  logic [3:0]                 in_dest,
  input  logic [2:0]                 in_prior,
  output logic                       xfer_stop,
  output logic                       pg_req,
  input  logic                       pg_gnt,
  input  logic [PAGE_AW-1:0]         pg_addr,
  output logic                       sram_wr_en,
  output logic [PAGE_AW+PAGE_W-1:0]  sram_wr_addr,
  output logic [15:0]                sram_wr_data,
  output logic                       link_wr_en,
  output logic [PAGE_AW-1:0]         link_wr_addr,
  output logic [PAGE_AW-1:0]         link_wr_data,
  output logic                       desc_vld,
  input  logic                       desc_rdy,
  output logic [PAGE_AW-1:0]         desc_head,
  output logic [LEN_W-1:0]           desc_len,
  output logic [3:0]                 desc_dest,
  output logic [2:0]                 desc_prior,
  output logic                       desc_err,
  output logic [15:0]                drop_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StData = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;
  localparam logic [1:0] StDesc = 2'd3;

  logic [1:0]                state_q, state_d;
  logic                      spare_vld_q, spare_vld_d;
  logic [PAGE_AW-1:0]        spare_q, spare_d;
  logic [PAGE_AW-1:0]        cur_q, cur_d;
  logic [PAGE_AW-1:0]        head_q, head_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [3:0]                dest_q, dest_d;
  logic [2:0]                prior_q, prior_d;
  logic                      err_q, err_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic [PAGE_W-1:0]         off_q, off_d;
  logic                      need_pg_q, need_pg_d;
  logic                      sram_wr_en_q, sram_wr_en_d;
  logic [PAGE_AW+PAGE_W-1:0] sram_wr_addr_q, sram_wr_addr_d;
  logic [15:0]               sram_wr_data_q, sram_wr_data_d;
  logic                      link_wr_en_q, link_wr_en_d;
  logic [PAGE_AW-1:0]        link_wr_addr_q, link_wr_addr_d;
  logic [PAGE_AW-1:0]        link_wr_data_q, link_wr_data_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;

  logic                      consume;
  logic [PAGE_AW-1:0]        wr_page;
  logic [LEN_W-1:0]          hdr_len;
  logic [1:0]                drop_inc;
  logic [16:0]               drop_sum;
  logic                      unused_hdr;

  assign hdr_len    = in_data[LEN_W-1:0];
  assign unused_hdr = ^in_data[15:LEN_W];

  assign pg_req    = ~rst & ~spare_vld_q;
  assign xfer_stop = ~rst & ((state_q == StDesc) | ((state_q == StIdle) & ~spare_vld_q));

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    head_d         = head_q;
    len_d          = len_q;
    dest_d         = dest_q;
    prior_d        = prior_q;
    err_d          = err_q;
    rem_d          = rem_q;
    off_d          = off_q;
    need_pg_d      = need_pg_q;
    sram_wr_en_d   = 1'b0;
    sram_wr_addr_d = sram_wr_addr_q;
    sram_wr_data_d = sram_wr_data_q;
    link_wr_en_d   = 1'b0;
    link_wr_addr_d = link_wr_addr_q;
    link_wr_data_d = link_wr_data_q;
    consume        = 1'b0;
    wr_page        = need_pg_q ? spare_q : cur_q;

    case (state_q)
      StIdle: begin
        if (in_vld) begin
          len_d     = hdr_len;
          dest_d    = in_dest;
          prior_d   = in_prior;
          rem_d     = hdr_len;
          off_d     = '0;
          need_pg_d = 1'b0;
          err_d     = 1'b0;
          if (hdr_len == '0) begin
            head_d  = '0;
            state_d = StDesc;
          end else if (!spare_vld_q) begin
            head_d  = '0;
            err_d   = 1'b1;
            state_d = StDrop;
          end else begin
            head_d  = spare_q;
            cur_d   = spare_q;
            consume = 1'b1;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (in_vld) begin
          rem_d = rem_q - LEN_W'(1);
          if (need_pg_q && !spare_vld_q) begin
            // No page for this word: discard it and the rest of the packet.
            err_d   = 1'b1;
            state_d = (rem_q == LEN_W'(1)) ? StDesc : StDrop;
          end else begin
            if (need_pg_q) begin
              consume        = 1'b1;
              cur_d          = spare_q;
              link_wr_en_d   = 1'b1;
              link_wr_addr_d = cur_q;
              link_wr_data_d = spare_q;
            end
            sram_wr_en_d   = 1'b1;
            sram_wr_addr_d = {wr_page, off_q};
            sram_wr_data_d = in_data;
            off_d          = off_q + PAGE_W'(1);
            need_pg_d      = (&off_q) && (rem_q != LEN_W'(1));
            if (rem_q == LEN_W'(1)) state_d = StDesc;
          end
        end
      end
      StDrop: begin
        if (rem_q == '0) begin
          state_d = StDesc;
        end else if (in_vld) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = StDesc;
        end
      end
      StDesc: begin
        if (desc_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Spare page: consumption and refill never coincide since pg_req needs it empty.
  always_comb begin
    spare_vld_d = spare_vld_q;
    spare_d     = spare_q;
    if (consume) spare_vld_d = 1'b0;
    if (pg_req && pg_gnt) begin
      spare_vld_d = 1'b1;
      spare_d     = pg_addr;
    end
  end

  // Errored handshake and a stray header in DESC can land in the same cycle.
  always_comb begin
    drop_inc   = 2'(state_q == StDesc && desc_rdy && err_q) + 2'(state_q == StDesc && in_vld);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      spare_vld_q    <= 1'b0;
      spare_q        <= '0;
      cur_q          <= '0;
      head_q         <= '0;
      len_q          <= '0;
      dest_q         <= '0;
      prior_q        <= '0;
      err_q          <= 1'b0;
      rem_q          <= '0;
      off_q          <= '0;
      need_pg_q      <= 1'b0;
      sram_wr_en_q   <= 1'b0;
      sram_wr_addr_q <= '0;
      sram_wr_data_q <= '0;
      link_wr_en_q   <= 1'b0;
      link_wr_addr_q <= '0;
      link_wr_data_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      spare_vld_q    <= spare_vld_d;
      spare_q        <= spare_d;
      cur_q          <= cur_d;
      head_q         <= head_d;
      len_q          <= len_d;
      dest_q         <= dest_d;
      prior_q        <= prior_d;
      err_q          <= err_d;
      rem_q          <= rem_d;
      off_q          <= off_d;
      need_pg_q      <= need_pg_d;
      sram_wr_en_q   <= sram_wr_en_d;
      sram_wr_addr_q <= sram_wr_addr_d;
      sram_wr_data_q <= sram_wr_data_d;
      link_wr_en_q   <= link_wr_en_d;
      link_wr_addr_q <= link_wr_addr_d;
      link_wr_data_q <= link_wr_data_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign sram_wr_en   = sram_wr_en_q;
  assign sram_wr_addr = sram_wr_addr_q;
  assign sram_wr_data = sram_wr_data_q;
  assign link_wr_en   = link_wr_en_q;
  assign link_wr_addr = link_wr_addr_q;
  assign link_wr_data = link_wr_data_q;
  assign desc_vld     = (state_q == StDesc);
  assign desc_head    = head_q;
  assign desc_len     = len_q;
  assign desc_dest    = dest_q;
  assign desc_prior   = prior_q;
  assign desc_err     = err_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_ingress_page_writer.sv
// Randomized bench for ingress_page_writer against a word-index/page-list reference model.
module tb_ingress_page_writer;
  localparam int PAGE_AW = 11;
  localparam int PAGE_W  = 3;
  localparam int LEN_W   = 9;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_vld;
  logic [15:0]               in_data;
  logic [3:0]                in_dest;
  logic [2:0]                in_prior;
  logic                      xfer_stop, pg_req, pg_gnt;
  logic [PAGE_AW-1:0]        pg_addr;
  logic                      sram_wr_en;
  logic [PAGE_AW+PAGE_W-1:0] sram_wr_addr;
  logic [15:0]               sram_wr_data;
  logic                      link_wr_en;
  logic [PAGE_AW-1:0]        link_wr_addr, link_wr_data;
  logic                      desc_vld, desc_rdy;
  logic [PAGE_AW-1:0]        desc_head;
  logic [LEN_W-1:0]          desc_len;
  logic [3:0]                desc_dest;
  logic [2:0]                desc_prior;
  logic                      desc_err;
  logic [15:0]               drop_cnt;

  always #5 clk = ~clk;

  ingress_page_writer #(.PAGE_AW(PAGE_AW), .PAGE_W(PAGE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_dest(in_dest),
    .in_prior(in_prior), .xfer_stop(xfer_stop), .pg_req(pg_req), .pg_gnt(pg_gnt),
    .pg_addr(pg_addr), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .link_wr_en(link_wr_en), .link_wr_addr(link_wr_addr),
    .link_wr_data(link_wr_data), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
    .desc_head(desc_head), .desc_len(desc_len), .desc_dest(desc_dest),
    .desc_prior(desc_prior), .desc_err(desc_err), .drop_cnt(drop_cnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: spare page, packet progress by word index, pending descriptor.
  bit               m_sp_vld, m_in_pkt, m_dropping, m_desc, m_err;
  logic [10:0]      m_sp, m_cur, m_head;
  int               m_len, m_idx, m_drop;
  logic [3:0]       m_dest;
  logic [2:0]       m_prior;
  bit               e_sram, e_link;
  logic [13:0]      e_sram_addr;
  logic [15:0]      e_sram_data;
  logic [10:0]      e_link_from, e_link_to;
  int               gnt_pct = 50, rdy_pct = 100, vld_pct = 100, pkts = 0;

  task automatic model_reset();
    m_sp_vld = 0; m_in_pkt = 0; m_dropping = 0; m_desc = 0; m_err = 0;
    m_sp = '0; m_cur = '0; m_head = '0; m_len = 0; m_idx = 0; m_drop = 0;
    m_dest = '0; m_prior = '0; e_sram = 0; e_link = 0;
  endtask

  task automatic bump_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".xfer_stop"}, 32'(xfer_stop), 0);
    check({tag, ".pg_req"}, 32'(pg_req), 0);
    check({tag, ".sram_wr_en"}, 32'(sram_wr_en), 0);
    check({tag, ".sram_wr_addr"}, 32'(sram_wr_addr), 0);
    check({tag, ".sram_wr_data"}, 32'(sram_wr_data), 0);
    check({tag, ".link_wr_en"}, 32'(link_wr_en), 0);
    check({tag, ".link_wr_addr"}, 32'(link_wr_addr), 0);
    check({tag, ".link_wr_data"}, 32'(link_wr_data), 0);
    check({tag, ".desc_vld"}, 32'(desc_vld), 0);
    check({tag, ".desc_head"}, 32'(desc_head), 0);
    check({tag, ".desc_len"}, 32'(desc_len), 0);
    check({tag, ".desc_err"}, 32'(desc_err), 0);
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  task automatic check_state();
    check("pg_req", 32'(pg_req), 32'(!m_sp_vld));
    check("xfer_stop", 32'(xfer_stop), 32'(m_desc || (!m_in_pkt && !m_sp_vld)));
    check("desc_vld", 32'(desc_vld), 32'(m_desc));
    if (m_desc) begin
      check("desc_head", 32'(desc_head), 32'(m_head));
      check("desc_len", 32'(desc_len), 32'(m_len));
      check("desc_dest", 32'(desc_dest), 32'(m_dest));
      check("desc_prior", 32'(desc_prior), 32'(m_prior));
      check("desc_err", 32'(desc_err), 32'(m_err));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic check_writes();
    check("sram_wr_en", 32'(sram_wr_en), 32'(e_sram));
    if (e_sram) begin
      check("sram_wr_addr", 32'(sram_wr_addr), 32'(e_sram_addr));
      check("sram_wr_data", 32'(sram_wr_data), 32'(e_sram_data));
    end
    check("link_wr_en", 32'(link_wr_en), 32'(e_link));
    if (e_link) begin
      check("link_wr_addr", 32'(link_wr_addr), 32'(e_link_from));
      check("link_wr_data", 32'(link_wr_data), 32'(e_link_to));
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic step_model();
    bit consume;
    bit old_sp;
    consume = 0;
    old_sp  = m_sp_vld;
    e_sram  = 0;
    e_link  = 0;
    if (m_desc) begin
      if (in_vld) bump_drop();
      if (desc_rdy) begin
        if (m_err) bump_drop();
        m_desc = 0;
      end
    end else if (!m_in_pkt) begin
      if (in_vld) begin
        m_len = int'(in_data[8:0]); m_dest = in_dest; m_prior = in_prior;
        m_idx = 0; m_err = 0; m_dropping = 0;
        if (m_len == 0) begin
          m_head = '0; m_desc = 1;
        end else if (!m_sp_vld) begin
          m_head = '0; m_err = 1; m_dropping = 1; m_in_pkt = 1;
        end else begin
          m_head = m_sp; m_cur = m_sp; consume = 1; m_in_pkt = 1;
        end
      end
    end else if (in_vld) begin
      if (!m_dropping && m_idx % 8 == 0 && m_idx != 0) begin
        if (m_sp_vld) begin
          e_link = 1; e_link_from = m_cur; e_link_to = m_sp; m_cur = m_sp; consume = 1;
        end else begin
          m_dropping = 1; m_err = 1;
        end
      end
      if (!m_dropping) begin
        e_sram = 1;
        e_sram_addr = {m_cur, 3'(m_idx % 8)};
        e_sram_data = in_data;
      end
      m_idx++;
      if (m_idx == m_len) begin
        m_in_pkt = 0; m_desc = 1;
      end
    end
    if (consume) m_sp_vld = 0;
    if (pg_gnt && !old_sp) begin
      m_sp_vld = 1; m_sp = pg_addr;
    end
  endtask

  function automatic int pick_len();
    case ($urandom % 8)
      0:       return 0;
      1, 2:    return int'($urandom_range(1, 8));
      3, 4:    return int'($urandom_range(9, 17));
      5:       return int'($urandom_range(18, 40));
      6:       return int'($urandom_range(1, 3));
      default: return ($urandom % 4 == 0) ? 511 : int'($urandom_range(41, 120));
    endcase
  endfunction

  task automatic drive(input bit allow_new);
    int len;
    in_vld   = 1'b0;
    in_data  = 16'($urandom);
    in_dest  = 4'($urandom);
    in_prior = 3'($urandom);
    if (m_desc) begin
      in_vld = ($urandom % 32) == 0;
    end else if (m_in_pkt) begin
      in_vld = ($urandom % 100) < vld_pct;
    end else if (allow_new && ($urandom % 2 == 1)) begin
      len = pick_len();
      in_data[8:0] = 9'(len);
      in_vld = 1'b1;
      pkts++;
      case ($urandom % 4)
        0: gnt_pct = 0;
        1: gnt_pct = 10;
        2: gnt_pct = 50;
        default: gnt_pct = 100;
      endcase
      case ($urandom % 3)
        0: rdy_pct = 10;
        1: rdy_pct = 50;
        default: rdy_pct = 100;
      endcase
      vld_pct = ($urandom % 2 == 1) ? 100 : 50;
    end
    pg_gnt   = ($urandom % 100) < gnt_pct;
    pg_addr  = 11'($urandom);
    desc_rdy = ($urandom % 100) < rdy_pct;
  endtask

  task automatic cycle(input bit allow_new);
    @(negedge clk);
    check_state();
    drive(allow_new);
    step_model();
    @(posedge clk);
    #1;
    check_writes();
  endtask

  task automatic manual_cycle(input logic [15:0] data);
    @(negedge clk);
    check_state();
    in_vld = 1'b1; in_data = data; pg_gnt = 1'b0; desc_rdy = 1'b0;
    step_model();
    @(posedge clk);
    #1;
    check_writes();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (m_in_pkt || m_desc); i++) cycle(1'b0);
    check("drain_idle", 32'(m_in_pkt || m_desc), 0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_dest = '0; in_prior = '0;
    pg_gnt = 1'b0; pg_addr = '0; desc_rdy = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    while (pkts < 150) cycle(1'b1);
    drain();

    // Abandon a 6-word packet at its 4th word.
    gnt_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 20 && !m_sp_vld; i++) cycle(1'b0);
    manual_cycle(16'h0006);
    manual_cycle(16'($urandom));
    manual_cycle(16'($urandom));
    manual_cycle(16'($urandom));
    @(negedge clk);
    in_vld = 1'b1; in_data = 16'($urandom); rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    check_all_zero("rst_hold");
    rst = 1'b0; in_vld = 1'b0; pg_gnt = 1'b0;
    repeat (20) cycle(1'b0);

    while (pkts < 170) cycle(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
